// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Sequential binary-to-BCD converter (shift-and-add-3, one bit per
//           clock) with saturating two-digit output and held overflow flag.
// Revision: 1.0
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_W = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [BIN_W-1:0] bin_in,
    output logic             in_ready,
    output logic [3:0]       tens,
    output logic [3:0]       units,
    output logic             ovf,
    output logic             done
);

    localparam int                 c_CNT_W = $clog2(BIN_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BIN_W - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t             r_state;
    logic [BIN_W-1:0]   r_shift;
    logic [11:0]        r_scratch;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ovf_next;
    logic               r_ready;
    logic [3:0]         r_tens;
    logic [3:0]         r_units;
    logic               r_ovf;
    logic               r_done;

    logic [11:0]        w_adj;
    logic [11:0]        w_next_scratch;
    logic [BIN_W-1:0]   w_next_shift;
    logic               w_accept;
    logic               w_last;
    logic               w_bin_big;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Hundreds nibble is carried only so no carry is lost before the final shift.
    assign w_adj          = {add3(r_scratch[11:8]), add3(r_scratch[7:4]), add3(r_scratch[3:0])};
    assign w_next_scratch = {w_adj[10:0], r_shift[BIN_W-1]};
    assign w_next_shift   = {r_shift[BIN_W-2:0], 1'b0};

    assign w_accept  = in_valid && r_ready;
    assign w_last    = (r_cnt == c_LAST);
    assign w_bin_big = (11'(bin_in) > 11'd99);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_next <= 1'b0;
            r_ready    <= 1'b1;
            r_tens     <= 4'd0;
            r_units    <= 4'd0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift    <= bin_in;
                        r_scratch  <= '0;
                        r_cnt      <= '0;
                        r_ovf_next <= w_bin_big;
                        r_ready    <= 1'b0;
                        r_state    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_scratch <= w_next_scratch;
                    r_shift   <= w_next_shift;
                    r_cnt     <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_tens  <= r_ovf_next ? 4'd9 : w_next_scratch[7:4];
                        r_units <= r_ovf_next ? 4'd9 : w_next_scratch[3:0];
                        r_ovf   <= r_ovf_next;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = r_ready;
    assign tens     = r_tens;
    assign units    = r_units;
    assign ovf      = r_ovf;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_bin2bcd_seq
// Brief   : Directed self-checking bench for bin2bcd_seq (BIN_W = 7).
// Revision: 1.0
// ============================================================================
module tb_bin2bcd_seq;

    localparam int BIN_W = 7;

    logic             clk;
    logic             rstn;
    logic             in_valid;
    logic [BIN_W-1:0] bin_in;
    logic             in_ready;
    logic [3:0]       tens;
    logic [3:0]       units;
    logic             ovf;
    logic             done;

    int checks;
    int errors;

    logic [3:0] hold_t;
    logic [3:0] hold_u;
    logic       hold_o;

    bin2bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .bin_in   (bin_in),
        .in_ready (in_ready),
        .tens     (tens),
        .units    (units),
        .ovf      (ovf),
        .done     (done)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Starts at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic do_conv(input int v, input logic [3:0] et, input logic [3:0] eu,
                           input logic eo, input string name);
        int cyc;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before got %b want 1", name, in_ready);
        end
        in_valid = 1'b1;
        bin_in   = BIN_W'(v);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            checks++;
            if (in_ready !== 1'b0 || tens !== hold_t || units !== hold_u || ovf !== hold_o) begin
                errors++;
                $display("FAIL %s busy_cyc%0d got rdy=%b %0d/%0d ovf=%b want rdy=0 %0d/%0d ovf=%b",
                         name, cyc, in_ready, tens, units, ovf, hold_t, hold_u, hold_o);
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL %s latency got %0d want 8", name, cyc);
        end
        checks++;
        if (tens !== et || units !== eu || ovf !== eo || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s result got %0d/%0d ovf=%b rdy=%b want %0d/%0d ovf=%b rdy=1",
                     name, tens, units, ovf, in_ready, et, eu, eo);
        end
        hold_t = et;
        hold_u = eu;
        hold_o = eo;
    endtask

    task automatic check_quiet(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || in_ready !== 1'b1 || tens !== hold_t || units !== hold_u || ovf !== hold_o) begin
                errors++;
                $display("FAIL %s quiet%0d got done=%b rdy=%b %0d/%0d ovf=%b want done=0 rdy=1 %0d/%0d ovf=%b",
                         name, i, done, in_ready, tens, units, ovf, hold_t, hold_u, hold_o);
            end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        in_valid = 1'b1;
        bin_in = 7'd50;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || tens !== 4'd0 || units !== 4'd0 || ovf !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset got rdy=%b %0d/%0d ovf=%b done=%b want rdy=1 0/0 ovf=0 done=0",
                     in_ready, tens, units, ovf, done);
        end
        in_valid = 1'b0;
        rstn = 1'b1;
        hold_t = 4'd0;
        hold_u = 4'd0;
        hold_o = 1'b0;
        check_quiet(2, "reset_idle");
    endtask

    task automatic test_basic;
        do_conv(42, 4'd4, 4'd2, 1'b0, "conv42");
        check_quiet(2, "after42");
    endtask

    task automatic test_back_to_back;
        do_conv(0, 4'd0, 4'd0, 1'b0, "b2b_0");
        do_conv(99, 4'd9, 4'd9, 1'b0, "b2b_99");
        check_quiet(1, "after99");
    endtask

    task automatic test_overflow;
        do_conv(127, 4'd9, 4'd9, 1'b1, "ovf127");
        @(negedge clk);
        do_conv(5, 4'd0, 4'd5, 1'b0, "after_ovf5");
        check_quiet(1, "after5");
    endtask

    task automatic test_ignore_busy;
        int cyc;
        in_valid = 1'b1;
        bin_in = 7'd13;
        @(negedge clk);
        bin_in = 7'd77;
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (cyc !== 8 || tens !== 4'd1 || units !== 4'd3 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy got lat=%0d %0d/%0d ovf=%b want lat=8 1/3 ovf=0",
                     cyc, tens, units, ovf);
        end
        hold_t = 4'd1;
        hold_u = 4'd3;
        hold_o = 1'b0;
        check_quiet(10, "no77");
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1;
        bin_in = 7'd88;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #0.5;
        checks++;
        if (in_ready !== 1'b1 || tens !== 4'd0 || units !== 4'd0 || ovf !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b %0d/%0d ovf=%b done=%b want rdy=1 0/0 ovf=0 done=0",
                     in_ready, tens, units, ovf, done);
        end
        @(negedge clk);
        rstn = 1'b1;
        hold_t = 4'd0;
        hold_u = 4'd0;
        hold_o = 1'b0;
        check_quiet(10, "abort_no_done");
        do_conv(88, 4'd8, 4'd8, 1'b0, "reconv88");
    endtask

    task automatic test_all_values;
        for (int v = 0; v < 128; v++) begin
            logic [3:0] et;
            logic [3:0] eu;
            logic       eo;
            eo = (v > 99);
            et = eo ? 4'd9 : 4'(v / 10);
            eu = eo ? 4'd9 : 4'(v % 10);
            do_conv(v, et, eu, eo, $sformatf("sweep%0d", v));
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rstn     = 1'b0;
        in_valid = 1'b0;
        bin_in   = '0;
        hold_t   = 4'd0;
        hold_u   = 4'd0;
        hold_o   = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_ignore_busy();
        test_reset_mid();
        test_all_values();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
